// File: rtl/axicb_addr_arb_mux_if.sv
// ----------------------------------------------------------------------------
// axicb_addr_arb_mux_if
// Bundles the address-channel handshake signals around axicb_addr_arb_mux.
//   req_valid/req_ready/req_data : per-master address channels (master i owns
//                                  req_data[i*DATA_W +: DATA_W])
//   arb_req/arb_en/arb_grant     : link to the per-slave round-robin arbiter
//   out_valid/out_ready/out_data/out_id : registered channel toward the slave
// Modports:
//   master : the arb/mux stage itself (drives ready, arbiter request, output)
//   slave  : the surrounding environment (masters, arbiter, slave side)
// ----------------------------------------------------------------------------
interface axicb_addr_arb_mux_if #(
  parameter int REQ_NB = 4,
  parameter int DATA_W = 64
);
  localparam int ID_W = $clog2(REQ_NB);

  logic [REQ_NB-1:0]        req_valid;
  logic [REQ_NB-1:0]        req_ready;
  logic [REQ_NB*DATA_W-1:0] req_data;
  logic [REQ_NB-1:0]        arb_req;
  logic                     arb_en;
  logic [REQ_NB-1:0]        arb_grant;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [ID_W-1:0]          out_id;

  modport master (
    input  req_valid, req_data, arb_grant, out_ready,
    output req_ready, arb_req, arb_en, out_valid, out_data, out_id
  );

  modport slave (
    output req_valid, req_data, arb_grant, out_ready,
    input  req_ready, arb_req, arb_en, out_valid, out_data, out_id
  );
endinterface

// File: rtl/axicb_addr_arb_mux.sv
// ----------------------------------------------------------------------------
// axicb_addr_arb_mux
// Address-channel stage behind the crossbar's per-slave round-robin arbiter.
// In IDLE it forwards master valids to the arbiter and, once a grant comes
// back, locks onto that master (pulsing arb_en exactly once so the arbiter's
// rotation advances once per grant). In LOCKED it offers ready to the locked
// master only and captures its payload, tagged with the master index, into a
// one-entry output register.
// Ports:
//   aclk, srst : clock and synchronous active-high reset (the only reset)
//   bus        : axicb_addr_arb_mux_if.master (req_*, arb_*, out_*)
// Parameters: REQ_NB (2..4 masters), DATA_W (payload width),
//   MAX_LOCK (>=1, beats kept on one grant, burst build only)
// Optional feature: define AXICB_ADDR_BURST_LOCK_EN to keep the grant for up
//   to MAX_LOCK back-to-back beats (one transfer per cycle); without it every
//   handshake returns to IDLE (one transfer per two cycles).
// ----------------------------------------------------------------------------
module axicb_addr_arb_mux #(
  parameter int REQ_NB   = 4,
  parameter int DATA_W   = 64,
  parameter int MAX_LOCK = 4
) (
  input logic                   aclk,
  input logic                   srst,
  axicb_addr_arb_mux_if.master  bus
);
  localparam int ID_W = $clog2(REQ_NB);

  if (REQ_NB < 2 || REQ_NB > 4) begin : g_req_nb_chk
    $error("axicb_addr_arb_mux: REQ_NB must be in 2..4");
  end
  if (MAX_LOCK < 1) begin : g_max_lock_chk
    $error("axicb_addr_arb_mux: MAX_LOCK must be >= 1");
  end

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state;
  logic [ID_W-1:0]   sel;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic [ID_W-1:0]   out_id_r;

  logic              out_free;
  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic [ID_W-1:0]   grant_idx;
  logic              hs;
  logic              burst_more;

  // Locked master's channel, the lowest set grant bit, and the handshake
  // decode. Ready and arb_en are suppressed while srst is high so no master
  // transfers and the arbiter does not rotate during reset.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < REQ_NB; i++) begin
      if (sel == ID_W'(i)) begin
        sel_valid = bus.req_valid[i];
        sel_data  = bus.req_data[i*DATA_W +: DATA_W];
      end
    end

    grant_idx = '0;
    for (int i = REQ_NB - 1; i >= 0; i--) begin
      if (bus.arb_grant[i]) grant_idx = ID_W'(i);
    end

    out_free = ~out_valid_r | bus.out_ready;

    bus.arb_req   = (state == IDLE) ? bus.req_valid : '0;
    bus.arb_en    = ~srst & (state == IDLE) & (|bus.req_valid) & (|bus.arb_grant);
    bus.req_ready = '0;
    for (int i = 0; i < REQ_NB; i++) begin
      bus.req_ready[i] = ~srst & (state == LOCKED) & (sel == ID_W'(i)) & out_free;
    end

    hs = ~srst & (state == LOCKED) & sel_valid & out_free;
  end

`ifdef AXICB_ADDR_BURST_LOCK_EN
  localparam int LCNT_W = $clog2(MAX_LOCK + 1);
  logic [LCNT_W-1:0] lock_cnt;

  assign burst_more = (int'(lock_cnt) + 1) < MAX_LOCK;

  // Beats already taken on the current grant; zero whenever IDLE so every
  // entry to LOCKED starts a fresh count.
  always_ff @(posedge aclk) begin
    if (srst) begin
      lock_cnt <= '0;
    end else if (state == IDLE) begin
      lock_cnt <= '0;
    end else if (hs && burst_more) begin
      lock_cnt <= lock_cnt + 1'b1;
    end else if (hs || !sel_valid) begin
      lock_cnt <= '0;
    end
  end
`else
  assign burst_more = 1'b0;
`endif

  // Lock FSM and one-entry output register.
  always_ff @(posedge aclk) begin
    if (srst) begin
      state       <= IDLE;
      sel         <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_id_r    <= '0;
    end else begin
      // A load wins over a drain, so a simultaneous drain+load keeps valid.
      if (hs) begin
        out_valid_r <= 1'b1;
        out_data_r  <= sel_data;
        out_id_r    <= sel;
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.arb_en) begin
            sel   <= grant_idx;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (hs) begin
            if (!burst_more) state <= IDLE;
          end else if (!sel_valid) begin
            // Locked master withdrew valid: give the grant back.
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_id    = out_id_r;

endmodule
